// File: rtl/glan_led_pkg.sv
// Shared definitions for the GigaLAN LED controller.
// Optional lamp-test states are present only when GLAN_LAMP_TEST_EN is defined.
package glan_led_pkg;

  // Link codes as {LINK1000#, LINK100#}
  localparam logic [1:0] LINK_1G   = 2'b01;
  localparam logic [1:0] LINK_100M = 2'b10;
  localparam logic [1:0] LINK_NONE = 2'b11;

  // LED drive level that leaves the lamp dark
  localparam logic LED_OFF = 1'b1;

  typedef enum logic [2:0] {
    SEQ_WAIT_PG  = 3'd0,
`ifdef GLAN_LAMP_TEST_EN
    SEQ_LAMP_GRN = 3'd1,
    SEQ_LAMP_ORG = 3'd2,
    SEQ_LAMP_ACT = 3'd3,
`endif
    SEQ_RUN      = 3'd4
  } seq_state_t;

  typedef enum logic [1:0] {
    ACT_IDLE = 2'd0,
    ACT_ON   = 2'd1,
    ACT_OFF  = 2'd2
  } act_state_t;

  // 00 cannot come from a healthy PHY; treat it as "no link"
  function automatic logic [1:0] norm_code(input logic [1:0] code);
    return (code == 2'b00) ? LINK_NONE : code;
  endfunction

endpackage

// File: rtl/glan_led_port.sv
// One LAN port's LED set: input synchronizers, link-code debounce,
// activity blink FSM and registered active-low LED drive.
// Lamp-test decode is present only when GLAN_LAMP_TEST_EN is defined.
module glan_led_port
  import glan_led_pkg::*;
#(
  parameter int BLINK_HALF = 1638,
  parameter int DEB_CYC    = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  seq_state_t mode,
  input  logic       act_n,
  input  logic       link1000_n,
  input  logic       link100_n,
  output logic       speed1_led,
  output logic       speed2_led,
  output logic       act_led
);

  localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam int DW = $clog2(DEB_CYC + 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);
  localparam logic [DW-1:0] DEB_LAST   = DW'(DEB_CYC - 1);

  logic [1:0]    code_s1, code_s2;
  logic [2:0]    act_sync;
  logic [1:0]    raw_code, cand, acc;
  logic [DW-1:0] deb_cnt;
  logic          act_evt, linked, run;

  act_state_t    act_q, act_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          pend_q, pend_d;

  assign raw_code = norm_code(code_s2);
  assign act_evt  = act_sync[2] & ~act_sync[1];
  assign linked   = (acc != LINK_NONE);
  assign run      = (mode == SEQ_RUN);

  // Two-flop synchronizers; ACT# gets a third flop for falling-edge detect
  always_ff @(posedge clk) begin
    if (reset) begin
      code_s1  <= LINK_NONE;
      code_s2  <= LINK_NONE;
      act_sync <= '1;
    end else begin
      code_s1  <= {link1000_n, link100_n};
      code_s2  <= code_s1;
      act_sync <= {act_sync[1:0], act_n};
    end
  end

  // Accept a new link code only after it has held for DEB_CYC cycles
  always_ff @(posedge clk) begin
    if (reset) begin
      cand    <= LINK_NONE;
      acc     <= LINK_NONE;
      deb_cnt <= '0;
    end else if (raw_code == acc) begin
      cand    <= raw_code;
      deb_cnt <= '0;
    end else if (raw_code != cand) begin
      cand    <= raw_code;
      deb_cnt <= DW'(1);
      if (DEB_LAST == '0) acc <= raw_code;
    end else if (deb_cnt == DEB_LAST) begin
      acc     <= raw_code;
      deb_cnt <= '0;
    end else begin
      deb_cnt <= deb_cnt + 1'b1;
    end
  end

  // Activity FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      act_q       <= ACT_IDLE;
      blink_cnt_q <= '0;
      pend_q      <= 1'b0;
    end else begin
      act_q       <= act_d;
      blink_cnt_q <= blink_cnt_d;
      pend_q      <= pend_d;
    end
  end

  // Activity next state: fixed ON/OFF halves, pend re-arms one more blink
  always_comb begin
    act_d       = act_q;
    blink_cnt_d = blink_cnt_q;
    pend_d      = pend_q;
    if (!run || !linked) begin
      act_d       = ACT_IDLE;
      blink_cnt_d = '0;
      pend_d      = 1'b0;
    end else begin
      case (act_q)
        ACT_IDLE: begin
          if (act_evt) begin
            act_d       = ACT_ON;
            blink_cnt_d = '0;
          end
        end
        ACT_ON: begin
          if (act_evt) pend_d = 1'b1;
          if (blink_cnt_q == BLINK_LAST) begin
            act_d       = ACT_OFF;
            blink_cnt_d = '0;
          end else begin
            blink_cnt_d = blink_cnt_q + 1'b1;
          end
        end
        ACT_OFF: begin
          if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d = '0;
            if (pend_q || act_evt) begin
              act_d  = ACT_ON;
              pend_d = 1'b0;
            end else begin
              act_d = ACT_IDLE;
            end
          end else begin
            blink_cnt_d = blink_cnt_q + 1'b1;
            if (act_evt) pend_d = 1'b1;
          end
        end
        default: act_d = ACT_IDLE;
      endcase
    end
  end

  // Registered LED drive; ACT follows the FSM's next state so it lines up with it
  always_ff @(posedge clk) begin
    if (reset) begin
      speed1_led <= LED_OFF;
      speed2_led <= LED_OFF;
      act_led    <= LED_OFF;
    end else begin
      speed1_led <= LED_OFF;
      speed2_led <= LED_OFF;
      act_led    <= LED_OFF;
      case (mode)
        SEQ_RUN: begin
          speed1_led <= (acc != LINK_1G);
          speed2_led <= (acc != LINK_100M);
          act_led    <= (act_d != ACT_ON);
        end
`ifdef GLAN_LAMP_TEST_EN
        SEQ_LAMP_GRN: speed1_led <= ~LED_OFF;
        SEQ_LAMP_ORG: speed2_led <= ~LED_OFF;
        SEQ_LAMP_ACT: act_led    <= ~LED_OFF;
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/glan_led_seq.sv
// GigaLAN daughter-board LED controller top: ALL_PWRGD sync, global
// sequencer and NPORT per-port LED blocks.
// Define GLAN_LAMP_TEST_EN to insert a green/orange/ACT lamp test after power-good.
module glan_led_seq
  import glan_led_pkg::*;
#(
  parameter int NPORT      = 2,
  parameter int BLINK_HALF = 1638,
  parameter int DEB_CYC    = 16,
  parameter int LAMP_CYC   = 16384
) (
  input  logic             CLK32KHz,
  input  logic             Reset,
  input  logic             ALL_PWRGD,
  input  logic [NPORT-1:0] PActivity,
  input  logic [NPORT-1:0] Speed1P,
  input  logic [NPORT-1:0] Speed2P,
  output logic [NPORT-1:0] Speed1R,
  output logic [NPORT-1:0] Speed2R,
  output logic [NPORT-1:0] RActivity
);

  logic [1:0] pg_sync;
  logic       pg;
  seq_state_t seq_q, seq_d;

  assign pg = pg_sync[1];

  // ALL_PWRGD two-flop synchronizer
  always_ff @(posedge CLK32KHz) begin
    if (Reset) pg_sync <= '0;
    else       pg_sync <= {pg_sync[0], ALL_PWRGD};
  end

`ifdef GLAN_LAMP_TEST_EN
  localparam int LW = (LAMP_CYC > 1) ? $clog2(LAMP_CYC) : 1;
  localparam logic [LW-1:0] LAMP_LAST = LW'(LAMP_CYC - 1);

  logic [LW-1:0] lamp_cnt_q, lamp_cnt_d;

  // Sequencer state and lamp-phase counter
  always_ff @(posedge CLK32KHz) begin
    if (Reset) begin
      seq_q      <= SEQ_WAIT_PG;
      lamp_cnt_q <= '0;
    end else begin
      seq_q      <= seq_d;
      lamp_cnt_q <= lamp_cnt_d;
    end
  end

  // Power-good gating and lamp-test phase stepping
  always_comb begin
    seq_d      = seq_q;
    lamp_cnt_d = lamp_cnt_q;
    if (!pg) begin
      seq_d      = SEQ_WAIT_PG;
      lamp_cnt_d = '0;
    end else begin
      case (seq_q)
        SEQ_WAIT_PG: begin
          seq_d      = SEQ_LAMP_GRN;
          lamp_cnt_d = '0;
        end
        SEQ_LAMP_GRN, SEQ_LAMP_ORG, SEQ_LAMP_ACT: begin
          if (lamp_cnt_q == LAMP_LAST) begin
            lamp_cnt_d = '0;
            case (seq_q)
              SEQ_LAMP_GRN: seq_d = SEQ_LAMP_ORG;
              SEQ_LAMP_ORG: seq_d = SEQ_LAMP_ACT;
              default:      seq_d = SEQ_RUN;
            endcase
          end else begin
            lamp_cnt_d = lamp_cnt_q + 1'b1;
          end
        end
        SEQ_RUN: ;
        default: seq_d = SEQ_WAIT_PG;
      endcase
    end
  end
`else
  // Sequencer state
  always_ff @(posedge CLK32KHz) begin
    if (Reset) seq_q <= SEQ_WAIT_PG;
    else       seq_q <= seq_d;
  end

  // Power-good gating: straight to RUN
  always_comb begin
    seq_d = seq_q;
    if (!pg)                       seq_d = SEQ_WAIT_PG;
    else if (seq_q == SEQ_WAIT_PG) seq_d = SEQ_RUN;
  end
`endif

  // Ports see the next sequencer state so their registered LEDs switch with it
  for (genvar i = 0; i < NPORT; i++) begin : g_port
    glan_led_port #(
      .BLINK_HALF (BLINK_HALF),
      .DEB_CYC    (DEB_CYC)
    ) u_port (
      .clk        (CLK32KHz),
      .reset      (Reset),
      .mode       (seq_d),
      .act_n      (PActivity[i]),
      .link1000_n (Speed1P[i]),
      .link100_n  (Speed2P[i]),
      .speed1_led (Speed1R[i]),
      .speed2_led (Speed2R[i]),
      .act_led    (RActivity[i])
    );
  end

endmodule

// File: tb/tb_glan_led_seq.sv
// Self-checking bench for glan_led_seq (BLINK_HALF=4, DEB_CYC=3, LAMP_CYC=8).
// Works with or without GLAN_LAMP_TEST_EN defined.
module tb_glan_led_seq;

  localparam int NPORT = 2;
  localparam int BH    = 4;
  localparam int DEB   = 3;
  localparam int LAMP  = 8;
  localparam int HN    = 64;

  logic             clk = 1'b0;
  logic             rst;
  logic             pg;
  logic [NPORT-1:0] pact, sp1, sp2;
  logic [NPORT-1:0] s1r, s2r, ract;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  glan_led_seq #(
    .NPORT      (NPORT),
    .BLINK_HALF (BH),
    .DEB_CYC    (DEB),
    .LAMP_CYC   (LAMP)
  ) dut (
    .CLK32KHz  (clk),
    .Reset     (rst),
    .ALL_PWRGD (pg),
    .PActivity (pact),
    .Speed1P   (sp1),
    .Speed2P   (sp2),
    .Speed1R   (s1r),
    .Speed2R   (s2r),
    .RActivity (ract)
  );

  // Reference model: pin history sampled per edge, timestamped blinks
  int         cyc;
  logic [1:0] h_code [NPORT][HN];
  logic       h_act  [NPORT][HN];
  logic       h_pg   [HN];
  int         run_len;
  logic [1:0] m_acc  [NPORT];
  logic       m_idle [NPORT];
  logic       m_pend [NPORT];
  int         m_s    [NPORT];
  logic [NPORT-1:0] e_s1, e_s2, e_ra;

  function automatic logic [1:0] norm(input logic [1:0] c);
    return (c == 2'b00) ? 2'b11 : c;
  endfunction

  // Advance one clock edge, update the model with the inputs sampled at it, settle
  task automatic tick();
    logic       pgs, evt, same, lit;
    logic [1:0] old_acc, v;
    int         mode;  // 0 wait, 1 green, 2 orange, 3 act, 4 run
    @(posedge clk);
    cyc++;
    h_pg[cyc % HN] = pg;
    for (int p = 0; p < NPORT; p++) begin
      h_code[p][cyc % HN] = {sp1[p], sp2[p]};
      h_act[p][cyc % HN]  = pact[p];
    end
    if (rst) begin
      for (int k = 0; k < 8; k++) begin
        h_pg[(cyc - k) % HN] = 1'b0;
        for (int p = 0; p < NPORT; p++) begin
          h_code[p][(cyc - k) % HN] = 2'b11;
          h_act[p][(cyc - k) % HN]  = 1'b1;
        end
      end
      run_len = 0;
      for (int p = 0; p < NPORT; p++) begin
        m_acc[p] = 2'b11; m_idle[p] = 1'b1; m_pend[p] = 1'b0; m_s[p] = 0;
      end
      e_s1 = '1; e_s2 = '1; e_ra = '1;
    end else begin
      pgs     = h_pg[(cyc - 2) % HN];
      run_len = pgs ? run_len + 1 : 0;
      if (run_len == 0) mode = 0;
`ifdef GLAN_LAMP_TEST_EN
      else if (run_len <= LAMP)     mode = 1;
      else if (run_len <= 2 * LAMP) mode = 2;
      else if (run_len <= 3 * LAMP) mode = 3;
`endif
      else mode = 4;
      for (int p = 0; p < NPORT; p++) begin
        old_acc = m_acc[p];
        evt = h_act[p][(cyc - 3) % HN] && !h_act[p][(cyc - 2) % HN];
        v = norm(h_code[p][(cyc - 2) % HN]);
        same = 1'b1;
        for (int k = 3; k <= DEB + 1; k++)
          if (norm(h_code[p][(cyc - k) % HN]) != v) same = 1'b0;
        if (same) m_acc[p] = v;
        if (mode != 4 || old_acc == 2'b11) begin
          m_idle[p] = 1'b1; m_pend[p] = 1'b0;
        end else if (m_idle[p]) begin
          if (evt) begin m_idle[p] = 1'b0; m_s[p] = cyc; m_pend[p] = 1'b0; end
        end else if (cyc == m_s[p] + 2 * BH) begin
          if (m_pend[p] || evt) begin m_s[p] = cyc; m_pend[p] = 1'b0; end
          else m_idle[p] = 1'b1;
        end else if (evt) begin
          m_pend[p] = 1'b1;
        end
        lit = !m_idle[p] && (cyc < m_s[p] + BH);
        e_s1[p] = (mode == 1) ? 1'b0 : (mode == 4) ? (old_acc != 2'b01) : 1'b1;
        e_s2[p] = (mode == 2) ? 1'b0 : (mode == 4) ? (old_acc != 2'b10) : 1'b1;
        e_ra[p] = (mode == 3) ? 1'b0 : (mode == 4) ? !lit : 1'b1;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      pact = NPORT'($urandom); sp1 = NPORT'($urandom); sp2 = NPORT'($urandom); pg = 1'($urandom);
      tick();
      n_cmp++;
      if ({s1r, s2r, ract} !== 6'b111111) begin
        n_err++; $display("FAIL reset_held t=%0d got=%b exp=111111", cyc, {s1r, s2r, ract});
      end
    end
    rst = 1'b0; pg = 1'b0; pact = '1;
    for (int i = 0; i < 6; i++) begin
      sp1 = NPORT'($urandom); sp2 = NPORT'($urandom);
      tick();
      n_cmp++;
      if ({s1r, s2r, ract} !== 6'b111111) begin
        n_err++; $display("FAIL reset_nopg t=%0d got=%b exp=111111", cyc, {s1r, s2r, ract});
      end
    end
  endtask

  task automatic test_link_speed();
    pg = 1'b1; sp1 = '1; sp2 = '1; pact = '1;
    for (int i = 0; i < 6; i++) tick();
    sp1[0] = 1'b0; sp2[0] = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      n_cmp++;
      if (s1r[0] !== ((i >= 6) ? 1'b0 : 1'b1)) begin
        n_err++; $display("FAIL link_latency i=%0d got=%b exp=%b", i, s1r[0], (i >= 6) ? 1'b0 : 1'b1);
      end
      n_cmp++;
      if ({s1r, s2r, ract} !== {e_s1, e_s2, e_ra}) begin
        n_err++; $display("FAIL link_model t=%0d got=%b exp=%b", cyc, {s1r, s2r, ract}, {e_s1, e_s2, e_ra});
      end
    end
    sp1[0] = 1'b1; sp2[0] = 1'b0;
    tick(); tick();
    sp1[0] = 1'b0; sp2[0] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_cmp++;
      if ({s1r[0], s2r[0]} !== 2'b01) begin
        n_err++; $display("FAIL link_glitch t=%0d got=%b exp=01", cyc, {s1r[0], s2r[0]});
      end
    end
  endtask

  task automatic test_single_blink();
    sp1[1] = 1'b1; sp2[1] = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    pact[1] = 1'b0;
    for (int i = 1; i <= 14; i++) begin
      tick();
      pact[1] = 1'b1;
      n_cmp++;
      if (ract[1] !== ((i >= 3 && i <= 6) ? 1'b0 : 1'b1)) begin
        n_err++; $display("FAIL single_blink i=%0d got=%b exp=%b", i, ract[1], (i >= 3 && i <= 6) ? 1'b0 : 1'b1);
      end
      n_cmp++;
      if ({s1r, s2r, ract} !== {e_s1, e_s2, e_ra}) begin
        n_err++; $display("FAIL blink_model t=%0d got=%b exp=%b", cyc, {s1r, s2r, ract}, {e_s1, e_s2, e_ra});
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 30; i++) begin
      pact[0] = (i % 3 == 0) ? 1'b0 : 1'b1;
      tick();
      n_cmp++;
      if ({s1r, s2r, ract} !== {e_s1, e_s2, e_ra}) begin
        n_err++; $display("FAIL burst_model t=%0d got=%b exp=%b", cyc, {s1r, s2r, ract}, {e_s1, e_s2, e_ra});
      end
    end
    pact[0] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      n_cmp++;
      if ({s1r, s2r, ract} !== {e_s1, e_s2, e_ra}) begin
        n_err++; $display("FAIL burst_tail t=%0d got=%b exp=%b", cyc, {s1r, s2r, ract}, {e_s1, e_s2, e_ra});
      end
    end
    n_cmp++;
    if (ract[0] !== 1'b1) begin
      n_err++; $display("FAIL burst_idle got=%b exp=1", ract[0]);
    end
  endtask

  task automatic test_link_loss();
    pact[0] = 1'b0; tick(); pact[0] = 1'b1;
    tick(); tick(); tick();
    sp1[0] = 1'b1; sp2[0] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      n_cmp++;
      if ({s1r, s2r, ract} !== {e_s1, e_s2, e_ra}) begin
        n_err++; $display("FAIL loss_model t=%0d got=%b exp=%b", cyc, {s1r, s2r, ract}, {e_s1, e_s2, e_ra});
      end
    end
    n_cmp++;
    if ({s1r[0], s2r[0], ract[0]} !== 3'b111) begin
      n_err++; $display("FAIL loss_dark got=%b exp=111", {s1r[0], s2r[0], ract[0]});
    end
  endtask

  task automatic test_pwrgd();
    rst = 1'b1; pg = 1'b0; pact = '1;
    sp1 = 2'b10; sp2 = 2'b01;  // port0 1000M, port1 100M
    tick();
    rst = 1'b0; pg = 1'b1;
    for (int i = 1; i <= 14; i++) begin
      tick();
      n_cmp++;
      if ({s1r, s2r, ract} !== {e_s1, e_s2, e_ra}) begin
        n_err++; $display("FAIL pg_model t=%0d got=%b exp=%b", cyc, {s1r, s2r, ract}, {e_s1, e_s2, e_ra});
      end
    end
    n_cmp++;
`ifdef GLAN_LAMP_TEST_EN
    if ({s1r, s2r, ract} !== 6'b110011) begin
      n_err++; $display("FAIL lamp_orange got=%b exp=110011", {s1r, s2r, ract});
    end
`else
    if ({s1r, s2r, ract} !== 6'b100111) begin
      n_err++; $display("FAIL run_speeds got=%b exp=100111", {s1r, s2r, ract});
    end
`endif
    pg = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      n_cmp++;
      if (i >= 3 && {s1r, s2r, ract} !== 6'b111111) begin
        n_err++; $display("FAIL pg_drop i=%0d got=%b exp=111111", i, {s1r, s2r, ract});
      end else if ({s1r, s2r, ract} !== {e_s1, e_s2, e_ra}) begin
        n_err++; $display("FAIL pg_drop_model t=%0d got=%b exp=%b", cyc, {s1r, s2r, ract}, {e_s1, e_s2, e_ra});
      end
    end
    pg = 1'b1;
    for (int i = 0; i < 36; i++) begin
      pact = (i % 7 == 0) ? 2'b00 : 2'b11;
      tick();
      n_cmp++;
      if ({s1r, s2r, ract} !== {e_s1, e_s2, e_ra}) begin
        n_err++; $display("FAIL pg_rerise t=%0d got=%b exp=%b", cyc, {s1r, s2r, ract}, {e_s1, e_s2, e_ra});
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 2000; i++) begin
      rst = ($urandom_range(0, 399) == 0);
      if (pg) pg = ($urandom_range(0, 199) != 0);
      else    pg = ($urandom_range(0, 9) == 0);
      for (int p = 0; p < NPORT; p++) begin
        if ($urandom_range(0, 29) == 0) begin
          sp1[p] = 1'($urandom); sp2[p] = 1'($urandom);
        end
        pact[p] = ($urandom_range(0, 4) != 0);
      end
      tick();
      n_cmp++;
      if ({s1r, s2r, ract} !== {e_s1, e_s2, e_ra}) begin
        n_err++; $display("FAIL random t=%0d got=%b exp=%b", cyc, {s1r, s2r, ract}, {e_s1, e_s2, e_ra});
      end
    end
  endtask

  initial begin
    cyc = 16;
    run_len = 0;
    for (int k = 0; k < HN; k++) begin
      h_pg[k] = 1'b0;
      for (int p = 0; p < NPORT; p++) begin
        h_code[p][k] = 2'b11; h_act[p][k] = 1'b1;
      end
    end
    rst = 1'b1; pg = 1'b0; pact = '1; sp1 = '1; sp2 = '1;
    test_reset();
    test_link_speed();
    test_single_blink();
    test_back_to_back();
    test_link_loss();
    test_pwrgd();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
